// File: rtl/serial_alu_ctrl_if.sv
// Command/result handshake bundle for serial_alu_ctrl.
// The master side issues commands and consumes results.
interface serial_alu_ctrl_if #(
   parameter int WIDTH = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic [1:0]       op_sel;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] result;
   logic             carry;
   logic             zero;
   logic             overflow;

   modport master (
      output in_valid, op_a, op_b, op_sel, out_ready,
      input  in_ready, out_valid, result, carry, zero, overflow
   );

   modport slave (
      input  in_valid, op_a, op_b, op_sel, out_ready,
      output in_ready, out_valid, result, carry, zero, overflow
   );
endinterface

// File: rtl/serial_alu_ctrl.sv
// Bit-serial sequencer around an external 1-bit ALU slice: LSB-first, one bit per clock.
//
// state  | meaning
// IDLE   | waiting for a command; in_ready high
// RUN    | feeding one operand bit pair per cycle to the slice
// DONE   | result held on the bus until out_ready
module serial_alu_ctrl #(
   parameter int WIDTH = 16
) (
   input  logic clk,
   input  logic rst_n,
   serial_alu_ctrl_if.slave bus,
   output logic slice_a,
   output logic slice_b,
   output logic slice_cin,
   output logic slice_s0,
   output logic slice_s1,
   input  logic slice_result,
   input  logic slice_cout
);
   localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic [1:0]       op_q, op_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             cy_q, cy_d;
   logic             ovf_q, ovf_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
         op_q    <= '0;
         cnt_q   <= '0;
         cy_q    <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         res_q   <= res_d;
         op_q    <= op_d;
         cnt_q   <= cnt_d;
         cy_q    <= cy_d;
         ovf_q   <= ovf_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      a_d       = a_q;
      b_d       = b_q;
      res_d     = res_q;
      op_d      = op_q;
      cnt_d     = cnt_q;
      cy_d      = cy_q;
      ovf_d     = ovf_q;
      slice_a   = 1'b0;
      slice_b   = 1'b0;
      slice_cin = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (bus.in_valid) begin
               a_d     = bus.op_a;
               b_d     = bus.op_b;
               op_d    = bus.op_sel;
               cnt_d   = '0;
               res_d   = '0;
               cy_d    = bus.op_sel[1] & bus.op_sel[0];
               ovf_d   = 1'b0;
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            slice_a   = a_q[0];
            slice_b   = b_q[0];
            slice_cin = cy_q;
            a_d       = a_q >> 1;
            b_d       = b_q >> 1;
            res_d     = {slice_result, res_q[WIDTH-1:1]};
            // logic ops never report a carry, whatever the slice says
            cy_d      = op_q[1] & slice_cout;
            cnt_d     = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_LAST) begin
               ovf_d   = op_q[1] & (cy_q ^ slice_cout);
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            if (bus.out_ready) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign slice_s0      = op_q[0];
   assign slice_s1      = op_q[1];
   assign bus.in_ready  = (state_q == S_IDLE);
   assign bus.out_valid = (state_q == S_DONE);
   assign bus.result    = res_q;
   assign bus.carry     = cy_q;
   assign bus.overflow  = ovf_q;
   assign bus.zero      = (res_q == '0);
endmodule

// File: tb/tb_serial_alu_ctrl.sv
// Bench for serial_alu_ctrl with a behavioural 1-bit slice; results scoreboarded
// against a whole-word arithmetic model.
module tb_serial_alu_ctrl;
   localparam int WIDTH = 16;

   typedef struct packed {
      logic [WIDTH-1:0] res;
      logic             cy;
      logic             z;
      logic             ovf;
   } exp_t;

   logic clk;
   logic rst_n;
   logic slice_a, slice_b, slice_cin, slice_s0, slice_s1;
   logic slice_result, slice_cout;
   logic bb;

   int   n_cmp;
   int   n_err;
   exp_t sb[$];

   serial_alu_ctrl_if #(.WIDTH(WIDTH)) bus ();

   serial_alu_ctrl #(.WIDTH(WIDTH)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .bus          (bus),
      .slice_a      (slice_a),
      .slice_b      (slice_b),
      .slice_cin    (slice_cin),
      .slice_s0     (slice_s0),
      .slice_s1     (slice_s1),
      .slice_result (slice_result),
      .slice_cout   (slice_cout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // 1-bit slice: 00 AND, 01 OR, 10 ADD, 11 SUB (B inverted here)
   always_comb begin
      bb           = slice_s0 ? ~slice_b : slice_b;
      slice_result = 1'b0;
      slice_cout   = 1'b0;
      case ({slice_s1, slice_s0})
         2'b00:   slice_result = slice_a & slice_b;
         2'b01:   slice_result = slice_a | slice_b;
         default: begin
            slice_result = slice_a ^ bb ^ slice_cin;
            slice_cout   = (slice_a & bb) | (slice_a & slice_cin) | (bb & slice_cin);
         end
      endcase
   end

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_cmp++;
      if (obs !== exp_v) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp_v, $time);
      end
   endtask

   function automatic exp_t model(input logic [1:0] op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
      exp_t       e;
      logic [WIDTH:0] s;
      e = '0;
      s = '0;
      case (op)
         2'b00: e.res = a & b;
         2'b01: e.res = a | b;
         2'b10: begin
            s     = {1'b0, a} + {1'b0, b};
            e.res = s[WIDTH-1:0];
            e.cy  = s[WIDTH];
            e.ovf = (a[WIDTH-1] == b[WIDTH-1]) && (e.res[WIDTH-1] != a[WIDTH-1]);
         end
         default: begin
            s     = {1'b0, a} + {1'b0, ~b} + (WIDTH+1)'(1);
            e.res = s[WIDTH-1:0];
            e.cy  = s[WIDTH];
            e.ovf = (a[WIDTH-1] != b[WIDTH-1]) && (e.res[WIDTH-1] != a[WIDTH-1]);
         end
      endcase
      e.z = (e.res == '0);
      return e;
   endfunction

   task automatic wait_ready();
      int w;
      w = 0;
      while (!bus.in_ready && w < 40) begin
         @(negedge clk);
         w++;
      end
      check_val("in_ready_wait", 32'(bus.in_ready), 32'(1));
   endtask

   task automatic run_op(input logic [1:0] op, input logic [WIDTH-1:0] a,
                         input logic [WIDTH-1:0] b, input int hold);
      int   lat;
      exp_t e;
      exp_t got;
      @(negedge clk);
      wait_ready();
      bus.op_sel   = op;
      bus.op_a     = a;
      bus.op_b     = b;
      bus.in_valid = 1'b1;
      @(posedge clk);
      sb.push_back(model(op, a, b));
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.op_a     = WIDTH'($urandom);
      bus.op_b     = WIDTH'($urandom);
      bus.op_sel   = 2'($urandom);
      lat = 0;
      while (!bus.out_valid && lat < 40) begin
         check_val("run_in_ready", 32'(bus.in_ready), 32'(0));
         @(negedge clk);
         lat++;
      end
      check_val("latency", 32'(lat), 32'(WIDTH));
      got = {bus.result, bus.carry, bus.zero, bus.overflow};
      if (hold > 0) bus.in_valid = 1'b1;
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         check_val("hold_stable", 32'({bus.result, bus.carry, bus.zero, bus.overflow}), 32'(got));
         check_val("hold_out_valid", 32'(bus.out_valid), 32'(1));
         check_val("hold_in_ready", 32'(bus.in_ready), 32'(0));
      end
      if (sb.size() > 0) e = sb.pop_front();
      else begin
         e = '0;
         check_val("sb_empty", 32'(sb.size()), 32'(1));
      end
      check_val("result", 32'(bus.result), 32'(e.res));
      check_val("carry", 32'(bus.carry), 32'(e.cy));
      check_val("zero", 32'(bus.zero), 32'(e.z));
      check_val("overflow", 32'(bus.overflow), 32'(e.ovf));
      bus.out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.out_ready = 1'b0;
      check_val("idle_in_ready", 32'(bus.in_ready), 32'(1));
      check_val("idle_out_valid", 32'(bus.out_valid), 32'(0));
      check_val("idle_slice_abc", 32'({slice_a, slice_b, slice_cin}), 32'(0));
      check_val("idle_slice_sel", 32'({slice_s1, slice_s0}), 32'(op));
      bus.in_valid = 1'b0;
   endtask

   task automatic check_reset_state(input string tag);
      check_val({tag, "_in_ready"}, 32'(bus.in_ready), 32'(1));
      check_val({tag, "_out_valid"}, 32'(bus.out_valid), 32'(0));
      check_val({tag, "_result"}, 32'(bus.result), 32'(0));
      check_val({tag, "_flags"}, 32'({bus.carry, bus.zero, bus.overflow}), 32'(3'b010));
      check_val({tag, "_slice"}, 32'({slice_a, slice_b, slice_cin, slice_s1, slice_s0}), 32'(0));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      n_cmp         = 0;
      n_err         = 0;
      rst_n         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      bus.op_a      = '0;
      bus.op_b      = '0;
      bus.op_sel    = '0;
      repeat (2) @(negedge clk);
      check_reset_state("reset");
      rst_n = 1'b1;

      run_op(2'b10, 16'h1234, 16'h0FF0, 0);
      run_op(2'b11, 16'h0005, 16'h0005, 0);
      run_op(2'b11, 16'h0003, 16'h0005, 0);
      run_op(2'b10, 16'h7FFF, 16'h0001, 0);
      run_op(2'b10, 16'hFFFF, 16'h0001, 0);
      run_op(2'b00, 16'hF0F0, 16'h3C3C, 0);
      run_op(2'b01, 16'hF0F0, 16'h3C3C, 5);
      run_op(2'b11, 16'h8000, 16'h0001, 0);
      for (int i = 0; i < 6; i++)
         run_op(2'($urandom), WIDTH'($urandom), WIDTH'($urandom), i % 3);

      // abort an ADD after 7 RUN cycles
      @(negedge clk);
      wait_ready();
      bus.op_sel   = 2'b10;
      bus.op_a     = 16'h00FF;
      bus.op_b     = 16'h00FF;
      bus.in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.in_valid = 1'b0;
      repeat (6) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check_reset_state("midrun_rst");
      @(negedge clk);
      check_reset_state("midrun_rst_hold");
      rst_n = 1'b1;
      run_op(2'b10, 16'h0001, 16'h0001, 0);

      check_val("sb_drained", 32'(sb.size()), 32'(0));
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/serial_alu_ctrl.md
SERIAL_ALU_CTRL -- requirements
Module: serial_alu_ctrl

Interface
REQ-001 SHALL have parameter: WIDTH, 16, operand and result width in bits (WIDTH >= 2).
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port: in_valid  input  1  command present.
REQ-005 SHALL have port: in_ready  output  1  controller can accept a command.
REQ-006 SHALL have port: op_a  input  WIDTH  operand A.
REQ-007 SHALL have port: op_b  input  WIDTH  operand B.
REQ-008 SHALL have port: op_sel  input  2  operation: 00 AND, 01 OR, 10 ADD, 11 SUB (A-B).
REQ-009 SHALL have port: slice_a  output  1  A bit driven to the external 1-bit ALU slice.
REQ-010 SHALL have port: slice_b  output  1  B bit driven to the slice.
REQ-011 SHALL have port: slice_cin  output  1  carry-in driven to the slice.
REQ-012 SHALL have port: slice_s0  output  1  slice selector bit 0.
REQ-013 SHALL have port: slice_s1  output  1  slice selector bit 1.
REQ-014 SHALL have port: slice_result  input  1  slice result bit.
REQ-015 SHALL have port: slice_cout  input  1  slice carry-out.
REQ-016 SHALL have port: out_valid  output  1  result available.
REQ-017 SHALL have port: out_ready  input  1  consumer accepts result.
REQ-018 SHALL have port: result  output  WIDTH  assembled result.
REQ-019 SHALL have port: carry  output  1  final carry (SUB: 1 = no borrow); 0 for AND/OR.
REQ-020 SHALL have port: zero  output  1  result == 0.
REQ-021 SHALL have port: overflow  output  1  signed overflow for ADD/SUB; 0 for AND/OR.

Function
REQ-022 SHALL implement FSM states IDLE, RUN, DONE; in_ready = 1 only in IDLE, out_valid = 1 only in DONE.
REQ-023 SHALL, in IDLE on in_valid && in_ready, capture op_a, op_b, op_sel into internal registers, clear bit counter and result shift register, load carry register with op_sel[0] & op_sel[1] (1 for SUB, else 0), and enter RUN.
REQ-024 SHALL, in RUN, drive slice_a = A_reg[0], slice_b = B_reg[0], slice_cin = carry register, slice_s1/slice_s0 = captured op; slice performs B inversion for SUB.
REQ-025 SHALL, each RUN cycle, shift A_reg and B_reg right by one, shift slice_result into the result register MSB (right shift), load carry register with slice_cout, and increment the bit counter.
REQ-026 SHALL, on the RUN cycle with counter = WIDTH-1, also capture overflow = slice_cin XOR slice_cout (ADD/SUB only) and enter DONE.
REQ-027 SHALL assert out_valid exactly WIDTH cycles after the accepting clock edge (bit 0 processed first, LSB-first).
REQ-028 SHALL, in DONE, hold result, carry, zero, overflow stable until out_valid && out_ready, then return to IDLE at that edge.
REQ-029 SHALL compute zero combinationally from the result register; carry and overflow are forced 0 when captured op is AND or OR.
REQ-030 SHALL drive slice_a, slice_b, slice_cin to 0 outside RUN; slice_s1/slice_s0 always reflect the captured op register.
REQ-031 SHALL ignore in_valid outside IDLE; operands need not remain stable after acceptance.
REQ-032 SHALL not accept a new command in the same cycle DONE completes (no IDLE bypass); minimum command-to-command period WIDTH+2 cycles.
REQ-033 SHALL treat wrap-around in ADD/SUB modulo 2^WIDTH, with carry out of bit WIDTH-1 reported on carry.

Reset
REQ-034 SHALL, while rst_n = 0, asynchronously force state IDLE, all registers (operands, op, counter, carry, result, overflow) to 0, giving in_ready = 1, out_valid = 0, result = 0, carry = 0, overflow = 0, zero = 1, slice outputs 0.
REQ-035 SHALL, on reset asserted mid-RUN or in DONE, discard the operation with no result delivered; first accept possible on the first clock edge after rst_n deasserts.

Verification (WIDTH = 16, behavioural 1-bit slice model attached)
REQ-036 SHALL cover: ADD 0x1234 + 0x0FF0 -> result 0x2224, carry 0, zero 0, overflow 0, out_valid exactly 16 cycles after accept.
REQ-037 SHALL cover: SUB 0x0005 - 0x0005 -> 0x0000, zero 1, carry 1, overflow 0; SUB 0x0003 - 0x0005 -> 0xFFFE, carry 0.
REQ-038 SHALL cover: ADD 0x7FFF + 0x0001 -> 0x8000, overflow 1, carry 0; ADD 0xFFFF + 0x0001 -> 0x0000, carry 1, zero 1, overflow 0.
REQ-039 SHALL cover: AND 0xF0F0, 0x3C3C -> 0x3030; OR same operands -> 0xFCFC; carry 0, overflow 0 for both.
REQ-040 SHALL cover: out_ready held 0 for 5 cycles in DONE -> outputs stable, in_ready 0, concurrent in_valid ignored; out_ready 1 -> IDLE next edge.
REQ-041 SHALL cover: rst_n pulsed low after 7 RUN cycles -> immediate IDLE, out_valid 0, result 0; following ADD 0x0001 + 0x0001 -> 0x0002.
